// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types, defaults and helpers for the multiplier datapath
package mul_pkg;

  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;

  // Result register occupancy: empty, or holding a group sum awaiting handshake
  typedef enum logic {
    IDLE_OUT = 1'b0,
    HOLD     = 1'b1
  } out_state_e;

  // Source bit for position bit_pos of a sign-extended from_w-bit value:
  // bits above the source width replicate the source sign bit.
  function automatic int sext_idx(input int bit_pos, input int from_w);
    return (bit_pos < from_w) ? bit_pos : from_w - 1;
  endfunction

endpackage

// File: rtl/acc_add_ovf.sv
// rtl/acc_add_ovf.sv - accumulator adder with sign-extended product operand and overflow flag
module acc_add_ovf
  import mul_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic [ACC_W-1:0] ext;

  // Sign-extend the product to accumulator width, bit by bit at elaboration time
  for (genvar i = 0; i < ACC_W; i++) begin : g_sext
    assign ext[i] = prod[sext_idx(i, PROD_W)];
  end

  // Wrapping add; overflow when both operands share a sign the result lacks
  always_comb begin
    sum = acc + ext;
    ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  end

endmodule

// File: rtl/mul_product_accumulator.sv
// rtl/mul_product_accumulator.sv - accumulates groups of LEN signed products with valid/ready output
module mul_product_accumulator
  import mul_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  out_state_e       state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] nxt;
  logic [CNT_W-1:0] cnt;
  logic             ovf_sticky;
  logic             add_ovf;
  logic             accept;
  logic             last;

  acc_add_ovf #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W)
  ) u_add (
    .acc (acc),
    .prod(in_prod),
    .sum (nxt),
    .ovf (add_ovf)
  );

  // A held result may be drained in the same cycle a new product (even the
  // group's last) is taken, so the input only stalls on an undrained result.
  always_comb begin
    out_valid = (state == HOLD);
    in_ready  = !flush && (!out_valid || out_ready);
    accept    = in_valid && in_ready;
    last      = (cnt == LAST);
  end

  // Group accumulation and output register; flush only touches the partial group
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE_OUT;
      acc        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      out_sum    <= '0;
      out_ovf    <= 1'b0;
    end else begin
      if (flush) begin
        acc        <= '0;
        cnt        <= '0;
        ovf_sticky <= 1'b0;
      end else if (accept) begin
        if (last) begin
          out_sum    <= nxt;
          out_ovf    <= ovf_sticky | add_ovf;
          acc        <= '0;
          cnt        <= '0;
          ovf_sticky <= 1'b0;
        end else begin
          acc        <= nxt;
          cnt        <= cnt + CNT_W'(1);
          ovf_sticky <= ovf_sticky | add_ovf;
        end
      end

      // A completing group wins over a drain so the new sum is never lost
      if (accept && last) begin
        state <= HOLD;
      end else if (out_ready) begin
        state <= IDLE_OUT;
      end
    end
  end

endmodule

// File: tb/tb_mul_product_accumulator.sv
// tb/tb_mul_product_accumulator.sv - scoreboard bench for mul_product_accumulator
module tb_mul_product_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        a_flush = 1'b0, a_valid = 1'b0, a_ordy = 1'b1;
  logic [7:0]  a_prod = '0;
  logic        a_ready, a_ovalid, a_ovf;
  logic [15:0] a_sum;

  logic        b_flush = 1'b0, b_valid = 1'b0, b_ordy = 1'b1;
  logic [7:0]  b_prod = '0;
  logic        b_ready, b_ovalid, b_ovf;
  logic [8:0]  b_sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [16:0] qa[$];
  logic [9:0]  qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_product_accumulator #(.PROD_W(8), .ACC_W(16), .LEN(4)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_valid), .in_ready(a_ready), .in_prod(a_prod),
    .out_valid(a_ovalid), .out_ready(a_ordy), .out_sum(a_sum), .out_ovf(a_ovf)
  );

  mul_product_accumulator #(.PROD_W(8), .ACC_W(9), .LEN(4)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_valid), .in_ready(b_ready), .in_prod(b_prod),
    .out_valid(b_ovalid), .out_ready(b_ordy), .out_sum(b_sum), .out_ovf(b_ovf)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: pop expected result on every output handshake
  always @(negedge clk) begin
    if (!rst && a_ovalid && a_ordy) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_result: got 0x%0h with nothing expected", a_sum);
      end else begin
        logic [16:0] e;
        e = qa.pop_front();
        if ({a_ovf, a_sum} !== e) begin
          errors++;
          $display("FAIL a_result: got ovf=%0b sum=0x%0h expected ovf=%0b sum=0x%0h",
                   a_ovf, a_sum, e[16], e[15:0]);
        end
      end
    end
    if (!rst && b_ovalid && b_ordy) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_result: got 0x%0h with nothing expected", b_sum);
      end else begin
        logic [9:0] e;
        e = qb.pop_front();
        if ({b_ovf, b_sum} !== e) begin
          errors++;
          $display("FAIL b_result: got ovf=%0b sum=0x%0h expected ovf=%0b sum=0x%0h",
                   b_ovf, b_sum, e[9], e[8:0]);
        end
      end
    end
  end

  // Present one product and hold it until the DUT takes it (bounded)
  task automatic push(input bit sel_b, input logic [7:0] p);
    bit ok;
    int t;
    ok = 1'b0;
    t  = 0;
    if (sel_b) begin b_valid = 1'b1; b_prod = p; end
    else       begin a_valid = 1'b1; a_prod = p; end
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = sel_b ? b_ready : a_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: product 0x%0h not accepted within %0d cycles", p, t);
    end
    if (sel_b) b_valid = 1'b0;
    else       a_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", 32'(a_ovalid), 0);
    chk("rst_out_sum", 32'(a_sum), 0);
    chk("rst_out_ovf", 32'(a_ovf), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(a_ready), 1);
    @(posedge clk); #1;

    // Basic group: 35 - 20 - 21 - 49 = -55
    qa.push_back({1'b0, 16'hFFC9});
    push(0, 8'h23); push(0, 8'hEC); push(0, 8'hEB); push(0, 8'hCF);
    @(negedge clk);
    chk("basic_out_valid", 32'(a_ovalid), 1);
    chk("basic_in_ready", 32'(a_ready), 1);
    @(posedge clk); #1;

    // Backpressure: result held, input stalls, drain and accept together
    a_ordy = 1'b0;
    qa.push_back({1'b0, 16'hFFC9});
    qa.push_back({1'b0, 16'h01A4});
    push(0, 8'h23); push(0, 8'hEC); push(0, 8'hEB); push(0, 8'hCF);
    a_valid = 1'b1;
    a_prod  = 8'h69;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 32'(a_ready), 0);
      chk("bp_sum_stable", 32'(a_sum), 32'hFFC9);
      @(posedge clk); #1;
    end
    a_ordy = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_drain", 32'(a_ready), 1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    chk("bp_out_valid_drop", 32'(a_ovalid), 0);
    @(posedge clk); #1;
    push(0, 8'h69); push(0, 8'h69); push(0, 8'h69);

    // Back-to-back groups, one product per cycle
    qa.push_back({1'b0, 16'h0004});
    qa.push_back({1'b0, 16'h0004});
    c0 = cyc;
    for (int i = 0; i < 8; i++) push(0, 8'h01);
    chk("b2b_cycles", 32'(cyc - c0), 8);
    @(posedge clk); #1;

    // Flush discards partial group and blocks the concurrent product
    push(0, 8'h05); push(0, 8'h07);
    a_flush = 1'b1; a_valid = 1'b1; a_prod = 8'h09;
    @(negedge clk);
    chk("flush_in_ready", 32'(a_ready), 0);
    @(posedge clk); #1;
    a_flush = 1'b0; a_valid = 1'b0;
    qa.push_back({1'b0, 16'h0008});
    for (int i = 0; i < 4; i++) push(0, 8'h02);
    @(posedge clk); #1;

    // Reset mid-group
    push(0, 8'h03); push(0, 8'h03);
    rst = 1'b1; a_valid = 1'b1; a_prod = 8'h03;
    @(posedge clk); #1;
    rst = 1'b0; a_valid = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(a_ovalid), 0);
    chk("midrst_out_sum", 32'(a_sum), 0);
    @(posedge clk); #1;
    qa.push_back({1'b0, 16'h000C});
    for (int i = 0; i < 4; i++) push(0, 8'h03);

    // Overflow on 9-bit accumulator: 4*105 = 420 wraps to -92
    qb.push_back({1'b1, 9'h1A4});
    qb.push_back({1'b0, 9'h004});
    for (int i = 0; i < 4; i++) push(1, 8'h69);
    for (int i = 0; i < 4; i++) push(1, 8'h01);

    repeat (3) @(posedge clk);
    #1;
    chk("a_queue_drained", 32'(qa.size()), 0);
    chk("b_queue_drained", 32'(qb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_product_accumulator.md
Name: mul_product_accumulator

Overview:
Downstream stage of the 4x4 Wallace-tree multiplier. Consumes its 8-bit products (signed interpretation: A signed, B unsigned, so P is a two's-complement 8-bit value), sign-extends and accumulates LEN of them, then emits the group sum with a valid/ready handshake. Forms the accumulate half of a dot-product/MAC datapath.

Parameters:
PROD_W, 8, product width from multiplier (signed)
ACC_W, 16, accumulator/result width (signed, must be >= PROD_W)
LEN, 4, products per result group (>= 1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  discard partial group (synchronous)
in_valid  input  1  product valid
in_ready  output  1  block can accept a product this cycle
in_prod  input  PROD_W  product from multiplier, two's complement
out_valid  output  1  group result valid
out_ready  input  1  consumer accepts result
out_sum  output  ACC_W  signed sum of LEN products
out_ovf  output  1  signed overflow occurred within the group

Behaviour:
- One clock (clk), synchronous active-high reset (rst); all state updates on rising edge of clk.
- Reset: acc=0, cnt=0, ovf_sticky=0, out_valid=0, out_sum=0, out_ovf=0; in_ready=1 the cycle after reset deasserts. Reset mid-group or with a pending result discards everything.
- in_ready = !flush && (!out_valid || out_ready) (combinational). Product accepted when in_valid && in_ready.
- Accept: nxt = acc + sext(in_prod), wraps modulo 2^ACC_W; signed overflow detected when operand signs equal and result sign differs; ovf_sticky |= overflow.
- If cnt != LEN-1: acc<=nxt, cnt<=cnt+1.
- If cnt == LEN-1 (last of group): out_sum<=nxt, out_ovf<=ovf_sticky|overflow, out_valid<=1, acc<=0, cnt<=0, ovf_sticky<=0. Latency: result visible 1 cycle after last product accepted.
- Output states: IDLE_OUT (out_valid=0) / HOLD (out_valid=1). HOLD -> IDLE_OUT on out_ready unless a new group completes the same cycle (then stays HOLD with new value). out_sum/out_ovf stable while out_valid && !out_ready.
- Simultaneous drain and accept allowed (full throughput, 1 product/cycle, no bubble).
- LEN=1: every accepted product produces a result next cycle.
- flush: acc, cnt, ovf_sticky cleared; any product on in_valid that cycle is not accepted (in_ready=0); pending out_valid result retained and still handshaken normally. rst has priority over flush.
- out_sum and out_ovf hold last value after handshake (not cleared).
- cnt width: $clog2(LEN) min 1.

Decomposition:
- Shared package mul_pkg: PROD_W/ACC_W defaults, output-state enum (IDLE_OUT, HOLD), sign-extension helper function.
- One sub-module: acc_add_ovf (ACC_W signed adder with sign-extended PROD_W operand and overflow flag, combinational).

Test Plan:
- Basic group, out_ready=1: products 0x23, 0xEC, 0xEB, 0xCF on consecutive cycles -> one cycle later out_valid=1, out_sum=0xFFC9 (-55), out_ovf=0; in_ready stays 1.
- Backpressure: same group, out_ready=0 for 5 cycles, then in_valid held with 0x69 -> in_ready=0, out_sum stable at 0xFFC9; on out_ready=1 product accepted same cycle, out_valid drops next cycle.
- Back-to-back groups: 8 consecutive 0x01 with out_ready=1 -> two results of 0x0004, no idle cycles on input.
- Overflow (ACC_W=9, LEN=4): four 0x69 (105) -> out_sum=0x1A4 (wrapped -92), out_ovf=1; next group of four 0x01 -> out_sum=0x004, out_ovf=0.
- Flush: accept 0x05, 0x07, assert flush with in_valid=1 and in_prod=0x09 -> 0x09 not accepted; then four 0x02 -> out_sum=0x0008.
- Reset mid-operation: accept 2 products, pulse rst one cycle with in_valid=1 -> out_valid=0, out_sum=0; following four 0x03 -> out_sum=0x000C.
